// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions.
//   XLEN_DEF       default address / instruction width
//   fetch_state_e  fetch FSM states (FETCH issues requests, DRAIN waits out dropped responses)
//   fetch_entry_t  {instr, pc} pair as presented to decode at the default width
//   OPC_*          RV32 opcodes of the redirecting instructions, shared with program_counter
package fetch_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used twice by the fetch stage (pc-tag queue and instruction buffer).
// Ports:
//   iCLK, iRST   clock, synchronous active-high reset
//   iClear       empty the FIFO on the next edge (redirect)
//   iPush/iData  write an entry; ignored when full unless a pop frees a slot the same cycle
//   iPop         drop the head; ignored when empty
//   oHead        head entry, all zeros while empty
//   oCount       occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iClear,
  input  logic                     iPush,
  input  T                         iData,
  input  logic                     iPop,
  output T                         oHead,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop, empty;

  assign empty   = (count_q == '0);
  assign do_pop  = iPop && !empty;
  assign do_push = iPush && ((count_q != CW'(DEPTH)) || do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge iCLK) begin
    if (iRST || iClear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked by the occupancy count.
  always_ff @(posedge iCLK) begin
    if (do_push && !iRST && !iClear) mem_q[wr_ptr_q] <= iData;
  end

  assign oHead  = empty ? T'('0) : mem_q[rd_ptr_q];
  assign oCount = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage between program_counter and decode. Issues in-order reads for iPC, tags each
// request with its PC, buffers returned words and hands {instr, pc} to decode.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned-PC stall with sticky oMisalign).
// Ports:
//   iCLK, iRST                      clock, synchronous active-high reset
//   iPC                             current fetch address
//   iFlush                          redirect: drop buffered and in-flight words
//   oPCAdvance                      request accepted this cycle, PC may step
//   oIMemReq/oIMemAddr/iIMemGnt     memory request handshake
//   iIMemRvalid/iIMemRdata          in-order read data
//   oValid/oInstr/oInstrPC/iReady   decode handshake
//   oMisalign                       sticky misaligned-fetch flag (0 unless the macro is set)
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [XLEN-1:0] iPC,
  input  logic            iFlush,
  output logic            oPCAdvance,
  output logic            oIMemReq,
  output logic [XLEN-1:0] oIMemAddr,
  input  logic            iIMemGnt,
  input  logic            iIMemRvalid,
  input  logic [XLEN-1:0] iIMemRdata,
  output logic            oValid,
  output logic [XLEN-1:0] oInstr,
  output logic [XLEN-1:0] oInstrPC,
  input  logic            iReady,
  output logic            oMisalign
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  fetch_state_e   state_q, state_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  outstanding;   // tag-queue occupancy == requests still awaiting data
  logic [CW-1:0]  buf_count;
  logic [CW:0]    credit_used;
  logic [XLEN-1:0] tag_head;
  entry_t         buf_head, buf_in;
  logic           accept, rsp_keep, rsp_drop, fetch_blocked;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (iFlush)                                    misalign_d = 1'b0;
    else if (state_q == FETCH && iPC[1:0] != 2'b00) misalign_d = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end

  assign fetch_blocked = misalign_q || (iPC[1:0] != 2'b00);
  assign oMisalign     = misalign_q;
`else
  assign fetch_blocked = 1'b0;
  assign oMisalign     = 1'b0;
`endif

  // Buffered plus outstanding words never exceed DEPTH, so a response always has a slot.
  assign credit_used = {1'b0, buf_count} + {1'b0, outstanding};
  assign oIMemReq    = !iRST && (state_q == FETCH) && (credit_used < (CW+1)'(DEPTH))
                       && !iFlush && !fetch_blocked;
  assign accept      = oIMemReq && iIMemGnt;
  assign oPCAdvance  = accept;
  assign oIMemAddr   = iPC;

  assign rsp_keep = iIMemRvalid && (drop_q == '0);
  assign rsp_drop = iIMemRvalid && (drop_q != '0);

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (rsp_drop) drop_d = drop_q - CW'(1);
    // Everything still in flight after this cycle's response becomes a response to discard.
    if (iFlush) drop_d = drop_d + outstanding - CW'(rsp_keep);
    case (state_q)
      FETCH:   if (iFlush && drop_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_d == '0)           state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= FETCH;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_fifo (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iClear (iFlush),
    .iPush  (accept),
    .iData  (iPC),
    .iPop   (rsp_keep),
    .oHead  (tag_head),
    .oCount (outstanding)
  );

  assign buf_in = '{instr: iIMemRdata, pc: tag_head};

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_instr_fifo (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iClear (iFlush),
    .iPush  (rsp_keep),
    .iData  (buf_in),
    .iPop   (oValid && iReady),
    .oHead  (buf_head),
    .oCount (buf_count)
  );

  assign oValid   = (buf_count != '0);
  assign oInstr   = buf_head.instr;
  assign oInstrPC = buf_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            iCLK = 1'b0;
  logic            iRST, iFlush, iIMemGnt, iIMemRvalid, iReady;
  logic [XLEN-1:0] iPC, iIMemRdata, oIMemAddr, oInstr, oInstrPC;
  logic            oPCAdvance, oIMemReq, oValid, oMisalign;

  instruction_fetch #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iPC         (iPC),
    .iFlush      (iFlush),
    .oPCAdvance  (oPCAdvance),
    .oIMemReq    (oIMemReq),
    .oIMemAddr   (oIMemAddr),
    .iIMemGnt    (iIMemGnt),
    .iIMemRvalid (iIMemRvalid),
    .iIMemRdata  (iIMemRdata),
    .oValid      (oValid),
    .oInstr      (oInstr),
    .oInstrPC    (oInstrPC),
    .iReady      (iReady),
    .oMisalign   (oMisalign)
  );

  always #5 iCLK = ~iCLK;

  // Memory model: in-order responses, each tagged with the redirect epoch it was issued in.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          rdy;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];     // accepted PCs of the current epoch not yet consumed by decode
  int          arrived;      // how many of exp_q have been delivered by memory
  int          epoch, cyc, last_rdy;
  int          n_cmp, n_bad, acc_total, pop_total;
  int          gnt_pct, rdy_pct, lat_min, lat_max;
  logic [31:0] pc_reg;
  bit          mis;
  bit          s_acc, s_pop, s_valid;
  logic [31:0] s_pc;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int old_pending();
    int n = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit flush, input logic [31:0] new_pc);
    bit pres, gnt, rdy, exp_req, pc_ok;
    int oldp, r;
    @(negedge iCLK);
    pres = !rst && mq.size() > 0 && mq[0].rdy <= cyc;
    gnt  = ($urandom_range(99) < gnt_pct);
    rdy  = ($urandom_range(99) < rdy_pct);
    iRST = rst; iFlush = flush; iPC = pc_reg; iIMemGnt = gnt; iReady = rdy;
    iIMemRvalid = pres;
    iIMemRdata  = pres ? memw(mq[0].addr) : $urandom;
    #1;
    oldp  = old_pending();
    pc_ok = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
    pc_ok = (pc_reg[1:0] == 2'b00);
`endif
    exp_req = !rst && !flush && oldp == 0 && exp_q.size() < DEPTH && !mis && pc_ok;
    check_eq("req", oIMemReq, exp_req);
    check_eq("advance", oPCAdvance, exp_req && gnt);
    check_eq("addr", oIMemAddr, pc_reg);
    if (!rst) begin
      check_eq("valid", oValid, arrived != 0);
      check_eq("drop", dut.drop_q, oldp);
      check_eq("misalign", oMisalign, mis);
      if (arrived == 0) begin
        check_eq("instr_empty", oInstr, 0);
        check_eq("pc_empty", oInstrPC, 0);
      end
    end
    s_acc   = exp_req && gnt;
    s_valid = oValid;
    s_pc    = oInstrPC;
    s_pop   = !rst && oValid && rdy;
    if (s_pop && arrived > 0) begin
      check_eq("pop_pc", oInstrPC, exp_q[0]);
      check_eq("pop_instr", oInstr, memw(exp_q[0]));
    end
    @(posedge iCLK);
    if (rst) begin
      mq.delete(); exp_q.delete();
      arrived = 0; mis = 0; pc_reg = new_pc; last_rdy = 0;
    end else begin
      if (s_pop && arrived > 0) begin
        void'(exp_q.pop_front());
        arrived--;
        pop_total++;
      end
      if (pres) begin
        if (mq[0].epoch == epoch) arrived++;
        void'(mq.pop_front());
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      if (!flush && oldp == 0 && pc_reg[1:0] != 2'b00) mis = 1;
`endif
      if (s_acc) begin
        r = cyc + $urandom_range(lat_max, lat_min);
        if (r <= last_rdy) r = last_rdy + 1;
        mq.push_back('{addr: pc_reg, epoch: epoch, rdy: r});
        last_rdy = r;
        exp_q.push_back(pc_reg);
        pc_reg += 4;
        acc_total++;
      end
      if (flush) begin
        epoch++;
        exp_q.delete();
        arrived = 0; mis = 0; pc_reg = new_pc;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    for (int i = 0; i < 3; i++) step(1, 0, start_pc);
  endtask

  task automatic set_mode(input int g, input int rd, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = rd; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    int first_acc, first_val, a0, p0, n;
    bit seen;
    iRST = 1; iFlush = 0; iPC = '0; iIMemGnt = 0; iIMemRvalid = 0; iIMemRdata = '0; iReady = 0;
    n_cmp = 0; n_bad = 0; acc_total = 0; pop_total = 0; epoch = 0; cyc = 0; last_rdy = 0;
    arrived = 0; mis = 0; pc_reg = '0;
    set_mode(100, 100, 1, 1);

    // Streaming: first word two cycles after first accept, then one per cycle.
    do_reset(32'h0);
    first_acc = -1; first_val = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      if (s_acc && first_acc < 0) first_acc = cyc - 1;
      if (s_valid && first_val < 0) first_val = cyc - 1;
    end
    check_eq("first_valid_latency", first_val - first_acc, 2);
    p0 = pop_total;
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    check_eq("sustained_rate", pop_total - p0, 10);

    // Back-pressure: exactly DEPTH accepts, then release in order.
    do_reset(32'h0);
    set_mode(100, 0, 1, 1);
    a0 = acc_total;
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    check_eq("backpressure_accepts", acc_total - a0, DEPTH);
    check_eq("backpressure_req_low", oIMemReq, 0);
    set_mode(100, 100, 1, 1);
    p0 = pop_total; seen = 0;
    for (int i = 0; i < 20 && pop_total - p0 < 4; i++) begin
      step(0, 0, 0);
      if (s_pop && !seen) begin check_eq("release_first_pc", s_pc, 32'h0); seen = 1; end
    end
    check_eq("release_pops", pop_total - p0, 4);

    // Flush with three requests in flight.
    do_reset(32'h0);
    set_mode(100, 100, 5, 5);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 1, 32'h100);
    #1;
    check_eq("flush_state_drain", dut.state_q, DRAIN);
    check_eq("flush_drop3", dut.drop_q, 3);
    check_eq("flush_empty", oValid, 0);
    set_mode(100, 100, 1, 1);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(0, 0, 0);
      if (s_pop) begin check_eq("resume_pc", s_pc, 32'h100); seen = 1; end
    end
    check_eq("resume_seen", seen, 1);

    // Flush coinciding with a response and a pop.
    do_reset(32'h0);
    set_mode(100, 100, 2, 2);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    step(0, 1, 32'h200);
    #1;
    check_eq("flush_rsp_drop", dut.drop_q, 1);
    p0 = pop_total;
    for (int i = 0; i < 30 && pop_total - p0 < 4; i++) step(0, 0, 0);
    check_eq("flush_rsp_resume", pop_total - p0, 4);

    // Random traffic with occasional redirects.
    do_reset(32'h0);
    set_mode(50, 70, 1, 3);
    p0 = pop_total; n = 0;
    while (pop_total - p0 < 1000 && n < 20000) begin
      if ($urandom_range(99) < 2) step(0, 1, {14'h0, 16'($urandom), 2'b00});
      else                        step(0, 0, 0);
      n++;
    end
    check_eq("random_done", pop_total - p0 >= 1000, 1);

`ifdef IFETCH_ALIGN_CHECK_EN
    do_reset(32'h102);
    set_mode(100, 100, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    #1;
    check_eq("misalign_set", oMisalign, 1);
    check_eq("misalign_no_req", oIMemReq, 0);
    step(0, 1, 32'h104);
    #1;
    check_eq("misalign_cleared", oMisalign, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0, 0, 0);
      if (s_pop) begin check_eq("misalign_resume_pc", s_pc, 32'h104); seen = 1; end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
